// File: rtl/pool_pkg.sv
// Shared definitions for the pooling pipeline: mode encoding and tree-depth helper.
package pool_pkg;

    typedef enum logic {
        MODE_MEAN = 1'b0,
        MODE_MAX  = 1'b1
    } pool_mode_e;

    // Number of pairwise reduction levels for a power-of-two neighborhood.
    function automatic int unsigned clog2_w(input int unsigned n);
        return (n <= 1) ? 0 : $clog2(n);
    endfunction

endpackage

// File: rtl/pool_stage.sv
// One registered reduction level: halves the element count with a pairwise add or signed max.
module pool_stage
    import pool_pkg::*;
#(
    parameter int unsigned IN_CNT = 2,
    parameter int unsigned W      = 17
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    in_valid,
    input  logic                    in_mode,
    input  logic [IN_CNT*W-1:0]     in_data,
    output logic                    out_valid,
    output logic                    out_mode,
    output logic [(IN_CNT/2)*W-1:0] out_data
);

    localparam int unsigned OUT_CNT = IN_CNT / 2;

    logic [OUT_CNT*W-1:0] red;

    // Operands are already sign-extended to W, so a plain add cannot overflow.
    always_comb begin
        red = '0;
        for (int j = 0; j < OUT_CNT; j++) begin
            if (in_mode == MODE_MAX) begin
                red[j*W +: W] = ($signed(in_data[2*j*W +: W]) > $signed(in_data[(2*j+1)*W +: W]))
                              ? in_data[2*j*W +: W] : in_data[(2*j+1)*W +: W];
            end else begin
                red[j*W +: W] = in_data[2*j*W +: W] + in_data[(2*j+1)*W +: W];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_mode  <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_mode  <= in_mode;
            out_data  <= red;
        end
    end

endmodule

// File: rtl/pool_pipe.sv
// Pipelined mean/max pooling over a packed neighborhood: one capture stage followed by
// log2(NH_SIZE) registered pairwise reduction levels, all sharing a single stall enable.
module pool_pipe
    import pool_pkg::*;
#(
    parameter int unsigned NH_SIZE = 4,
    parameter int unsigned DATA_W  = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_mode,
    input  logic [NH_SIZE*DATA_W-1:0] nh_vector,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         pool_out,
    output logic                      pool_mode
);

    localparam int unsigned LVLS     = clog2_w(NH_SIZE);
    localparam int unsigned SUM_W    = DATA_W + LVLS;
    localparam int unsigned TREE_CNT = 2 * NH_SIZE - 1;

    // All levels laid out back to back: capture elements first, final result last.
    wire  [TREE_CNT*SUM_W-1:0] tree;
    wire  [LVLS:0]             lvl_valid;
    wire  [LVLS:0]             lvl_mode;

    logic                      en;
    logic                      cap_valid;
    logic                      cap_mode;
    logic [NH_SIZE*SUM_W-1:0]  cap_data;
    logic [SUM_W-1:0]          top_sum;

    assign en       = out_ready || !out_valid;
    assign in_ready = en;

    always_ff @(posedge clock) begin
        if (reset) begin
            cap_valid <= 1'b0;
            cap_mode  <= 1'b0;
            cap_data  <= '0;
        end else if (en) begin
            cap_valid <= in_valid;
            cap_mode  <= in_mode;
            for (int k = 0; k < NH_SIZE; k++) begin
                cap_data[k*SUM_W +: SUM_W] <= SUM_W'($signed(nh_vector[k*DATA_W +: DATA_W]));
            end
        end
    end

    assign tree[NH_SIZE*SUM_W-1:0] = cap_data;
    assign lvl_valid[0]            = cap_valid;
    assign lvl_mode[0]             = cap_mode;

    for (genvar l = 0; l < LVLS; l++) begin : g_lvl
        localparam int unsigned IN_CNT  = NH_SIZE >> l;
        localparam int unsigned IN_OFF  = 2 * NH_SIZE - 2 * IN_CNT;
        localparam int unsigned OUT_OFF = IN_OFF + IN_CNT;

        pool_stage #(
            .IN_CNT(IN_CNT),
            .W     (SUM_W)
        ) u_stage (
            .clock    (clock),
            .reset    (reset),
            .en       (en),
            .in_valid (lvl_valid[l]),
            .in_mode  (lvl_mode[l]),
            .in_data  (tree[IN_OFF*SUM_W +: IN_CNT*SUM_W]),
            .out_valid(lvl_valid[l+1]),
            .out_mode (lvl_mode[l+1]),
            .out_data (tree[OUT_OFF*SUM_W +: (IN_CNT/2)*SUM_W])
        );
    end

    assign top_sum   = tree[(TREE_CNT-1)*SUM_W +: SUM_W];
    assign out_valid = lvl_valid[LVLS];
    assign pool_mode = lvl_mode[LVLS];
    // Taking DATA_W bits starting at LVLS is the arithmetic shift by LVLS, truncated.
    assign pool_out  = (lvl_mode[LVLS] == MODE_MAX) ? top_sum[DATA_W-1:0]
                                                    : top_sum[LVLS +: DATA_W];

endmodule

// File: tb/tb_pool_pipe.sv
// Bench for pool_pipe: directed table, stall/reset sequences, and a randomized scoreboard run.
module tb_pool_pipe;

    localparam int unsigned N = 4;
    localparam int unsigned W = 16;

    typedef struct packed {
        logic          mode;
        logic [63:0]   vec;
        logic [15:0]   exp;
    } vec_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid, in_ready, in_mode;
    logic          out_valid, out_ready, pool_mode;
    logic [N*W-1:0] nh_vector;
    logic [W-1:0]  pool_out;

    logic          d1_in_valid, d1_in_ready, d1_in_mode;
    logic          d1_out_valid, d1_out_ready, d1_pool_mode;
    logic [W-1:0]  d1_nh_vector, d1_pool_out;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    pool_pipe #(.NH_SIZE(N), .DATA_W(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_mode  (in_mode),
        .nh_vector(nh_vector),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .pool_out (pool_out),
        .pool_mode(pool_mode)
    );

    pool_pipe #(.NH_SIZE(1), .DATA_W(W)) dut1 (
        .clock    (clock),
        .reset    (reset),
        .in_valid (d1_in_valid),
        .in_ready (d1_in_ready),
        .in_mode  (d1_in_mode),
        .nh_vector(d1_nh_vector),
        .out_valid(d1_out_valid),
        .out_ready(d1_out_ready),
        .pool_out (d1_pool_out),
        .pool_mode(d1_pool_mode)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    // Reference: mean is floor(sum / 4) on plain integers, max is the largest element.
    function automatic logic [15:0] ref_pool(input logic mode, input logic [63:0] v);
        int s = 0;
        int m = -100000;
        int x;
        for (int k = 0; k < 4; k++) begin
            x = int'($signed(v[k*16 +: 16]));
            s += x;
            if (x > m) m = x;
        end
        if (mode) return m[15:0];
        s = (s >= 0) ? s / 4 : -((-s + 3) / 4);
        return s[15:0];
    endfunction

    function automatic logic [15:0] rand_elem();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 7))
            0:       return 16'h8000;
            1:       return 16'h7fff;
            default: return r[15:0];
        endcase
    endfunction

    task automatic run_one(input logic mode, input logic [63:0] v, input logic [15:0] exp,
                           input string name);
        int lat = 1;
        @(negedge clock);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_mode   = mode;
        nh_vector = v;
        #1 check({name, "_in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clock);
        in_valid = 1'b0;
        while (!out_valid && lat < 10) begin
            @(negedge clock);
            lat++;
        end
        check({name, "_latency"}, lat, 3);
        check({name, "_value"}, 32'(pool_out), 32'(exp));
        check({name, "_mode"}, 32'(pool_mode), 32'(mode));
    endtask

    vec_t        tbl[8];
    logic [15:0] exp_q[$];
    logic        exp_mq[$];

    initial begin
        logic [63:0] sv[8];
        logic        sm[8];
        logic [15:0] held_val;
        logic        held_mode;
        logic        held;
        logic [15:0] e;
        int          sent, got, extra;

        reset        = 1'b1;
        in_valid     = 1'b0;
        in_mode      = 1'b0;
        out_ready    = 1'b1;
        nh_vector    = '0;
        d1_in_valid  = 1'b0;
        d1_in_mode   = 1'b0;
        d1_out_ready = 1'b1;
        d1_nh_vector = '0;

        tbl[0] = '{1'b0, pk(4, 8, 12, 16), 16'd10};
        tbl[1] = '{1'b0, pk(-1, -2, 0, 0), 16'hffff};
        tbl[2] = '{1'b1, pk(-5, -3, -9, -7), 16'hfffd};
        tbl[3] = '{1'b0, pk(32767, 32767, 32767, 32767), 16'h7fff};
        tbl[4] = '{1'b0, pk(-32768, -32768, -32768, -32768), 16'h8000};
        tbl[5] = '{1'b1, pk(-32768, 32767, 0, 1), 16'h7fff};
        tbl[6] = '{1'b0, pk(1, 1, 1, 0), 16'h0000};
        tbl[7] = '{1'b0, pk(-32768, 32767, -32768, 32767), 16'hffff};

        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_pool_out", 32'(pool_out), 32'd0);
        check("rst_pool_mode", 32'(pool_mode), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_d1_out_valid", 32'(d1_out_valid), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_one(tbl[i].mode, tbl[i].vec, tbl[i].exp, $sformatf("tbl%0d", i));
        end

        // NH_SIZE=1 build: result is the element itself, one cycle later.
        @(negedge clock);
        d1_in_valid  = 1'b1;
        d1_in_mode   = 1'b1;
        d1_nh_vector = 16'h8000;
        @(negedge clock);
        d1_in_mode   = 1'b0;
        d1_nh_vector = 16'h1234;
        check("nh1_max_valid", 32'(d1_out_valid), 32'd1);
        check("nh1_max_value", 32'(d1_pool_out), 32'h8000);
        check("nh1_max_mode", 32'(d1_pool_mode), 32'd1);
        @(negedge clock);
        d1_in_valid = 1'b0;
        check("nh1_mean_value", 32'(d1_pool_out), 32'h1234);
        check("nh1_mean_mode", 32'(d1_pool_mode), 32'd0);

        // Randomized traffic with backpressure against the queue-based model.
        held = 1'b0;
        held_val = '0;
        held_mode = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clock);
            out_ready = ($urandom_range(0, 9) < 7);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_mode   = 1'($urandom_range(0, 1));
            for (int k = 0; k < 4; k++) begin
                e = rand_elem();
                nh_vector[k*16 +: 16] = e;
            end
            #1;
            if (held) begin
                check("rnd_hold_valid", 32'(out_valid), 32'd1);
                check("rnd_hold_value", 32'(pool_out), 32'(held_val));
                check("rnd_hold_mode", 32'(pool_mode), 32'(held_mode));
            end
            check("rnd_in_ready", 32'(in_ready), 32'(out_ready || !out_valid));
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_pool(in_mode, nh_vector));
                exp_mq.push_back(in_mode);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rnd_spurious_out", 32'd1, 32'd0);
                end else begin
                    check("rnd_value", 32'(pool_out), 32'(exp_q.pop_front()));
                    check("rnd_mode", 32'(pool_mode), 32'(exp_mq.pop_front()));
                end
            end
            held      = out_valid && !out_ready;
            held_val  = pool_out;
            held_mode = pool_mode;
        end
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            @(negedge clock);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            #1;
            if (out_valid) begin
                check("drain_value", 32'(pool_out), 32'(exp_q.pop_front()));
                check("drain_mode", 32'(pool_mode), 32'(exp_mq.pop_front()));
            end
        end
        check("drain_left", exp_q.size(), 0);
        @(negedge clock);
        in_valid = 1'b0;
        repeat (5) @(negedge clock);

        // Eight back-to-back neighborhoods, alternating modes, downstream stalled cycles 4-6.
        for (int i = 0; i < 8; i++) begin
            sm[i] = 1'(i % 2);
            sv[i] = pk(i * 1000 - 3000, -i * 7, i + 5, 12 - 3 * i);
        end
        sent = 0;
        got  = 0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            @(negedge clock);
            out_ready = !(c >= 4 && c <= 6);
            in_valid  = (sent < 8);
            if (sent < 8) begin
                in_mode   = sm[sent];
                nh_vector = sv[sent];
            end
            #1;
            if (c >= 4 && c <= 6) check("b2b_stall_in_ready", 32'(in_ready), 32'd0);
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                check($sformatf("b2b_value%0d", got), 32'(pool_out), 32'(ref_pool(sm[got], sv[got])));
                check($sformatf("b2b_mode%0d", got), 32'(pool_mode), 32'(sm[got]));
                got++;
            end
        end
        @(negedge clock);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (out_valid) extra++;
        end
        check("b2b_sent", sent, 8);
        check("b2b_got", got, 8);
        check("b2b_extra", extra, 0);

        // Reset with two neighborhoods in flight discards both.
        @(negedge clock);
        in_valid  = 1'b1;
        in_mode   = 1'b0;
        nh_vector = pk(100, 200, 300, 400);
        @(negedge clock);
        in_mode   = 1'b1;
        nh_vector = pk(1, 2, 3, 4);
        @(negedge clock);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1 check("rst_mid_out_valid_pre", 32'(out_valid), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1 check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (out_valid) extra++;
        end
        check("rst_mid_ghost_outputs", extra, 0);
        run_one(1'b0, pk(4, 8, 12, 16), 16'd10, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pool_pipe.md
POOL_PIPE -- requirements
Module: pool_pipe

Interface
REQ-001 Parameter NH_SIZE, default 4, number of elements per pooling neighborhood; SHALL be a power of two, 1..64.
REQ-002 Parameter DATA_W, default 16, two's-complement element and result width.
REQ-003 Derived LVLS = log2(NH_SIZE); SUM_W = DATA_W + LVLS (internal accumulation width).
REQ-004 clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  input neighborhood valid.
REQ-007 in_ready  out  1  block accepts input this cycle.
REQ-008 in_mode  in  1  pooling mode for this neighborhood: 0 = mean, 1 = max.
REQ-009 nh_vector  in  NH_SIZE*DATA_W  packed neighborhood; element k occupies bits [k*DATA_W +: DATA_W].
REQ-010 out_valid  out  1  pool_out holds a valid result.
REQ-011 out_ready  in  1  downstream accepts result this cycle.
REQ-012 pool_out  out  DATA_W  pooled result, signed.
REQ-013 pool_mode  out  1  mode of the result on pool_out.

Function
REQ-014 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-015 Pipeline SHALL have LVLS+1 register stages: input capture, then one registered reduction level per stage, each halving the element count.
REQ-016 Latency from input transfer to out_valid SHALL be exactly LVLS+1 cycles when no stall occurs (NH_SIZE=4: 3 cycles; NH_SIZE=1: 1 cycle).
REQ-017 Throughput SHALL be one neighborhood per cycle while out_ready is held high.
REQ-018 Stall: in_ready = out_ready || !out_valid; when in_ready is low every stage SHALL hold its data, valid and mode.
REQ-019 Bubbles (stage valid low) SHALL advance on each non-stalled cycle; data of invalid stages is don't-care.
REQ-020 Mode SHALL be captured with each neighborhood and travel with it; consecutive neighborhoods may use different modes.
REQ-021 Mean mode: each level SHALL form the sign-extended sum of pairs at SUM_W bits with no overflow; the final result SHALL be sum >>> LVLS (arithmetic shift, floor rounding) truncated to DATA_W.
REQ-022 Max mode: each level SHALL select the signed maximum of each pair; the final result SHALL be that maximum unchanged.
REQ-023 NH_SIZE=1: pool_out SHALL equal the single input element in either mode.
REQ-024 pool_out and pool_mode SHALL remain stable while out_valid && !out_ready.
REQ-025 in_valid while in_ready is low SHALL NOT be consumed; the source holds it.

Reset
REQ-026 While reset is high, all stage valids SHALL clear at the next clock edge; out_valid = 0, pool_out = 0, pool_mode = 0 after reset.
REQ-027 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight neighborhoods; none SHALL appear on the output afterwards.

Structure
REQ-029 Package pool_pkg SHALL hold the mode encoding (MODE_MEAN=0, MODE_MAX=1) and the clog2-derived width function.
REQ-030 One reduction level SHALL be a sub-module pool_stage (parameters IN_CNT, W), instantiated LVLS times via generate, each containing its own register and a mode-selected add/max per pair.
REQ-031 Stall enable SHALL be one shared signal driven from pool_pipe to all stages.

Verification
REQ-032 NH_SIZE=4, DATA_W=16, mean, inputs {4,8,12,16}, out_ready=1 -> pool_out = 10, out_valid exactly 3 cycles later.
REQ-033 Mean, inputs {-1,-2,0,0} -> pool_out = -1 (floor of -0.75); max, inputs {-5,-3,-9,-7} -> pool_out = -3.
REQ-034 Mean, inputs {32767,32767,32767,32767} -> pool_out = 32767 (no intermediate overflow).
REQ-035 Back-to-back 8 neighborhoods with alternating modes, out_ready low for cycles 4-6 -> in_ready low during stall, all 8 results in order with correct modes, none lost or duplicated.
REQ-036 Reset pulsed 1 cycle with 2 neighborhoods in flight -> out_valid never asserts for them; next input after reset produces its result 3 cycles later.
REQ-037 NH_SIZE=1 build, input 0x8000 in max mode -> pool_out = 0x8000 after 1 cycle.
